// File: rtl/atu_status_monitor_if.sv
// Port bundle between the ATU status monitor and its users (sequencer side and host readback).
// The slave modport is the monitor; master is whoever drives the raw line, tune_start and ack.
interface atu_status_monitor_if;
  logic        atu_status_raw;
  logic        tune_start;
  logic        result_ack;
  logic        atu_status;
  logic        status_rise;
  logic        status_fall;
  logic [15:0] busy_ms;
  logic [1:0]  result;
  logic        result_valid;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_dc;

  modport slave (
    input  atu_status_raw, tune_start, result_ack,
    output atu_status, status_rise, status_fall, busy_ms, result, result_valid,
           dbg_state, dbg_dc
  );

  modport master (
    output atu_status_raw, tune_start, result_ack,
    input  atu_status, status_rise, status_fall, busy_ms, result, result_valid,
           dbg_state, dbg_dc
  );
endinterface

// File: rtl/atu_status_monitor.sv
// Synchronises and debounces the AH-4 status line, then times each tune cycle
// and latches a result code plus busy duration for host readback.
module atu_status_monitor #(
    parameter int PS_DIV     = 2500,
    parameter int DEB_MS     = 5,
    parameter int ARM_MS     = 1000,
    parameter int TIMEOUT_MS = 9000
) (
    input logic                 clk,
    input logic                 rst_n,
    atu_status_monitor_if.slave bus
);
    localparam int PS_W = (PS_DIV > 1) ? $clog2(PS_DIV) : 1;
    localparam logic [PS_W-1:0] PS_RELOAD   = PS_W'(PS_DIV - 1);
    localparam logic [7:0]      DEB_LAST    = 8'(DEB_MS - 1);
    localparam logic [15:0]     ARM_LAST    = 16'(ARM_MS - 1);
    localparam logic [15:0]     TO_LAST     = 16'(TIMEOUT_MS - 1);
    localparam logic [15:0]     TO_BUSY     = 16'(TIMEOUT_MS);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

    logic [PS_W-1:0] ps;
    logic            tick;
    logic            sync1, s;
    logic [7:0]      dc;
    logic            atu_q, rise_q, fall_q;
    logic            ts_d, ts_edge;
    state_t          state;
    logic [15:0]     msc;
    logic [15:0]     busy_q;
    logic [1:0]      result_q;
    logic            valid_q;

    assign tick    = (ps == '0);
    assign ts_edge = bus.tune_start & ~ts_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps   <= '0;
            ts_d <= 1'b0;
        end else begin
            ps   <= tick ? PS_RELOAD : ps - 1'b1;
            ts_d <= bus.tune_start;
        end
    end

    // Edge pulses are registered with atu_status so they mark its first clk at the new level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            dc     <= '0;
            atu_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync1  <= bus.atu_status_raw;
            s      <= sync1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick) begin
                if (s == atu_q) begin
                    dc <= '0;
                end else if (dc == DEB_LAST) begin
                    atu_q  <= s;
                    dc     <= '0;
                    rise_q <= s;
                    fall_q <= ~s;
                end else begin
                    dc <= dc + 8'd1;
                end
            end
        end
    end

    // result_valid rises with entry to DONE and holds until result_ack is seen in DONE;
    // a new tune_start edge withdraws it at once, overriding a same-clk ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            msc      <= '0;
            busy_q   <= '0;
            result_q <= 2'b00;
            valid_q  <= 1'b0;
        end else if (ts_edge) begin
            state    <= ARMED;
            msc      <= '0;
            result_q <= 2'b00;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ARMED: begin
                    if (rise_q) begin
                        state <= BUSY;
                        msc   <= '0;
                    end else if (tick) begin
                        if (msc == ARM_LAST) begin
                            state    <= DONE;
                            result_q <= 2'b11;
                            busy_q   <= '0;
                            valid_q  <= 1'b1;
                        end else begin
                            msc <= msc + 16'd1;
                        end
                    end
                end
                BUSY: begin
                    if (fall_q) begin
                        state    <= DONE;
                        result_q <= 2'b01;
                        busy_q   <= msc;
                        valid_q  <= 1'b1;
                    end else if (tick) begin
                        if (msc == TO_LAST) begin
                            state    <= DONE;
                            result_q <= 2'b10;
                            busy_q   <= TO_BUSY;
                            valid_q  <= 1'b1;
                        end else if (msc != 16'hFFFF) begin
                            msc <= msc + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ack) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.atu_status   = atu_q;
    assign bus.status_rise  = rise_q;
    assign bus.status_fall  = fall_q;
    assign bus.busy_ms      = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.dbg_state    = state;
    assign bus.dbg_dc       = dc;
endmodule

// File: tb/tb_atu_status_monitor.sv
// Directed bench for atu_status_monitor with shortened timing parameters so every
// scenario (debounce, glitch, OK, no-response, timeout, priority, reset) fits a short run.
module tb_atu_status_monitor;
  localparam int PS  = 4;
  localparam int DEB = 5;
  localparam int ARM = 20;
  localparam int TO  = 60;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_BUSY = 2'd2, S_DONE = 2'd3;

  logic clk;
  logic rst_n;
  atu_status_monitor_if bus_if ();

  atu_status_monitor #(
    .PS_DIV(PS), .DEB_MS(DEB), .ARM_MS(ARM), .TIMEOUT_MS(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic [17:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.status_rise) rise_cnt++;
      if (bus_if.status_fall) fall_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus_if.tune_start = 1'b1;
    step(1);
    bus_if.tune_start = 1'b0;
  endtask

  task automatic ack();
    bus_if.result_ack = 1'b1;
    step(1);
    bus_if.result_ack = 1'b0;
  endtask

  task automatic wait_atu(input logic lvl, input int maxc, output int n);
    n = 0;
    while (bus_if.atu_status !== lvl && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int maxc, output int n);
    n = 0;
    while (bus_if.dbg_state !== st && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (bus_if.result_valid !== 1'b1 && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  // scoreboard: pop the expected {result, busy_ms} and compare with the latched readback
  task automatic check_result(input string tag, input int tol);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(bus_if.result_valid), 32'd1);
      chk({tag, "_state"}, 32'(bus_if.dbg_state), 32'(S_DONE));
      chk({tag, "_result"}, 32'(bus_if.result), 32'(e[17:16]));
      chk_range({tag, "_busy_ms"}, int'(bus_if.busy_ms), int'(e[15:0]) - tol, int'(e[15:0]) + tol);
    end
  endtask

  initial begin
    int n;
    int r0, f0;
    logic [15:0] busy_hold;

    rst_n = 1'b0;
    bus_if.atu_status_raw = 1'b1;
    bus_if.tune_start = 1'b0;
    bus_if.result_ack = 1'b0;

    // 1. reset with raw high, then debounce to 1
    step(3);
    chk("rst_atu_status", 32'(bus_if.atu_status), 32'd0);
    chk("rst_result", 32'(bus_if.result), 32'd0);
    chk("rst_valid", 32'(bus_if.result_valid), 32'd0);
    chk("rst_busy_ms", 32'(bus_if.busy_ms), 32'd0);
    chk("rst_state", 32'(bus_if.dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    wait_atu(1'b1, 60, n);
    chk_range("deb_rise_latency", n, DEB * PS, (DEB + 1) * PS + 3);
    step(3);
    chk("deb_rise_pulses", 32'(rise_cnt), 32'd1);
    chk("deb_no_fall", 32'(fall_cnt), 32'd0);

    bus_if.atu_status_raw = 1'b0;
    wait_atu(1'b0, 60, n);
    chk_range("deb_fall_latency", n, DEB * PS, (DEB + 1) * PS + 3);
    step(3);
    chk("deb_fall_pulses", 32'(fall_cnt), 32'd1);

    // 2. glitch of 4 ms is rejected
    r0 = rise_cnt;
    f0 = fall_cnt;
    bus_if.atu_status_raw = 1'b1;
    step((DEB - 1) * PS);
    bus_if.atu_status_raw = 1'b0;
    step(10 * PS);
    chk("glitch_atu_status", 32'(bus_if.atu_status), 32'd0);
    chk("glitch_rise", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_fall", 32'(fall_cnt - f0), 32'd0);
    chk("glitch_dc", 32'(bus_if.dbg_dc), 32'd0);

    // 3. normal tune: busy 30 ms
    exp_q.push_back({2'b01, 16'd30});
    pulse_start();
    chk("ok_armed", 32'(bus_if.dbg_state), 32'(S_ARMED));
    step(10 * PS - 1);
    bus_if.atu_status_raw = 1'b1;
    step(60);
    chk("ok_busy", 32'(bus_if.dbg_state), 32'(S_BUSY));
    step(30 * PS - 60);
    bus_if.atu_status_raw = 1'b0;
    wait_valid(20 * PS, n);
    check_result("ok", 1);
    busy_hold = bus_if.busy_ms;
    step(10);
    chk("ok_valid_held", 32'(bus_if.result_valid), 32'd1);
    ack();
    chk("ok_ack_valid", 32'(bus_if.result_valid), 32'd0);
    chk("ok_ack_state", 32'(bus_if.dbg_state), 32'(S_IDLE));
    chk("ok_ack_result_kept", 32'(bus_if.result), 32'd1);
    chk("ok_ack_busy_kept", 32'(bus_if.busy_ms), 32'(busy_hold));

    // 4. no response
    exp_q.push_back({2'b11, 16'd0});
    pulse_start();
    wait_valid(30 * PS, n);
    chk_range("nr_latency", n + 1, (ARM - 1) * PS, (ARM + 1) * PS + 2);
    check_result("nr", 0);

    // 6a. tune_start edge beats result_ack in DONE
    bus_if.tune_start = 1'b1;
    bus_if.result_ack = 1'b1;
    step(1);
    bus_if.tune_start = 1'b0;
    bus_if.result_ack = 1'b0;
    chk("prio_state", 32'(bus_if.dbg_state), 32'(S_ARMED));
    chk("prio_valid", 32'(bus_if.result_valid), 32'd0);
    chk("prio_result", 32'(bus_if.result), 32'd0);
    exp_q.push_back({2'b11, 16'd0});
    wait_valid(30 * PS, n);
    check_result("prio_nr", 0);
    ack();

    // 5. timeout: raw held high
    exp_q.push_back({2'b10, 16'(TO)});
    bus_if.atu_status_raw = 1'b1;
    pulse_start();
    wait_valid((TO + 2 * DEB + 5) * PS, n);
    check_result("to", 0);
    ack();
    bus_if.atu_status_raw = 1'b0;
    wait_atu(1'b0, 60, n);

    // 6b. reset mid-BUSY
    bus_if.atu_status_raw = 1'b1;
    pulse_start();
    wait_state(S_BUSY, 20 * PS, n);
    chk("rstb_reached_busy", 32'(bus_if.dbg_state), 32'(S_BUSY));
    step(5 * PS);
    rst_n = 1'b0;
    step(1);
    chk("rstb_state", 32'(bus_if.dbg_state), 32'(S_IDLE));
    chk("rstb_atu_status", 32'(bus_if.atu_status), 32'd0);
    chk("rstb_valid", 32'(bus_if.result_valid), 32'd0);
    chk("rstb_result", 32'(bus_if.result), 32'd0);
    chk("rstb_busy_ms", 32'(bus_if.busy_ms), 32'd0);
    chk("rstb_edges", 32'({bus_if.status_rise, bus_if.status_fall}), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
